// File: rtl/timer_pkg.sv
// Shared constants and FSM encoding for the countdown timer and its loader.
package timer_pkg;

    localparam int TIMER_W       = 5;
    localparam int DEFAULT_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_ARM  = 2'd2,
        ST_RUN  = 2'd3
    } state_t;

endpackage

// File: rtl/timer_loader_fifo.sv
// Small synchronous circular-buffer FIFO holding queued timer intervals.
module timer_loader_fifo #(
    parameter int W     = 5,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    // NOTE: the storage array is deliberately not reset; pointers and level alone say which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/timer_loader.sv
// Feeds queued reload values to the countdown timer, one interval after another,
// and counts completed intervals from the timer's trigger.
module timer_loader
    import timer_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int W     = TIMER_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    input  logic [W-1:0]             req_value,
    output logic                     req_ready,
    input  logic                     hold,
    input  logic                     timer_trigger,
    input  logic [W-1:0]             timer_count,
    output logic [W-1:0]             value,
    output logic                     valid,
    output logic                     enable,
    output logic                     busy,
    output logic                     done,
    output logic [7:0]               done_cnt,
    output logic [$clog2(DEPTH):0]   level
);

    state_t         state_q;
    state_t         state_d;
    logic           push;
    logic           pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic [W-1:0]   fifo_head;
    logic [W-1:0]   value_q;
    logic [7:0]     done_cnt_q;
    logic           unused_status;

    // timer_count is informational only; control decisions rely on timer_trigger.
    assign unused_status = ^timer_count;

    assign req_ready = !fifo_full;
    assign push      = req_valid && req_ready;

    timer_loader_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (req_value),
        .pop       (pop),
        .head      (fifo_head),
        .level     (level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d = ST_LOAD;
                    pop     = 1'b1;
                end
            end
            ST_LOAD: state_d = ST_ARM;
            ST_ARM:  state_d = ST_RUN;
            ST_RUN: begin
                if (timer_trigger) begin
                    if (!fifo_empty) begin
                        state_d = ST_LOAD;
                        pop     = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign valid    = (state_q == ST_LOAD);
    assign enable   = (state_q == ST_RUN) && !hold;
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_RUN) && timer_trigger;
    assign value    = value_q;
    assign done_cnt = done_cnt_q;

    // The head is captured as it is popped, so value stays stable through LOAD and beyond.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            value_q    <= '0;
            done_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (pop) begin
                value_q <= fifo_head;
            end
            if (done) begin
                done_cnt_q <= done_cnt_q + 8'd1;
            end
        end
    end

endmodule

// File: doc/timer_loader.md
Name: timer_loader

Overview:
- Upstream feeder for the 5-bit countdown timer.
- Accepts reload values from a producer over a ready/valid handshake and buffers them in a small FIFO.
- Drives the timer's value/valid/enable inputs, so the timer runs one queued interval after another without software involvement.
- Watches the timer's trigger to detect expiry, then reports completed intervals.

Parameters:
- DEPTH, 4, FIFO entries; must be a power of two, ≥2.
- W, 5, value width; matches the timer's value/count width.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- req_valid  in  1  producer offers req_value this cycle.
- req_value  in  W  interval to queue.
- req_ready  out  1  high when the FIFO is not full; transfer occurs when req_valid && req_ready at posedge.
- hold  in  1  pause request; while high in RUN, enable is forced low.
- timer_trigger  in  1  timer expiry indication (high while the timer count is zero).
- timer_count  in  W  timer's current count; used for status only.
- value  out  W  load value to the timer.
- valid  out  1  one-cycle load strobe to the timer.
- enable  out  1  count enable to the timer.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when an interval expires.
- done_cnt  out  8  number of completed intervals; wraps at 255→0.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset values (asynchronous, take effect immediately):
  - state=IDLE; FIFO empty; level=0.
  - value=0, valid=0, enable=0, busy=0, done=0, done_cnt=0.
  - req_ready=1 once reset is released.
- FIFO:
  - Circular buffer with a wrapping read pointer and write pointer.
  - Push on req_valid && req_ready.
  - Pop only on entry to LOAD.
  - Simultaneous push and pop while full is not possible, because req_ready is computed from registered level (no combinational bypass).
  - Simultaneous push and pop at any other level leaves level unchanged.
  - Push into an empty FIFO is visible to the FSM the following cycle.
  - req_value is stored unmodified; 0 is legal.
- FSM states: IDLE, LOAD, ARM, RUN.
  - IDLE: enable=0. If level≠0 → LOAD next cycle, popping the head into the value register.
  - LOAD (exactly 1 cycle): valid=1, value=popped entry, enable=0 → ARM.
  - ARM (exactly 1 cycle): valid=0, enable=0. This lets the timer settle its count and trigger after the load → RUN.
  - RUN: enable = !hold, combinational from registered state and the hold input.
  - RUN exit: if timer_trigger=1, then done=1 for one cycle and done_cnt increments.
    - If level≠0, go directly to LOAD, popping the next entry: back-to-back intervals have exactly 2 dead cycles (LOAD, ARM).
    - Otherwise go to IDLE.
  - timer_trigger is ignored outside RUN.
  - hold has no effect outside RUN. Asserting hold never suspends an in-progress LOAD or ARM.
- Latency:
  - A push into an empty, idle block produces valid 2 cycles after the accepting edge (1 cycle to register level, 1 cycle in LOAD).
  - Interval N (N≠0) with hold=0 gives RUN duration ≈ N cycles plus the timer's trigger latency. The loader itself adds none; it exits on the cycle it samples trigger high.
- Zero value: LOAD/ARM proceed normally; the timer reports trigger in ARM/RUN, so RUN exits on its first cycle. done still pulses once.
- value holds its last loaded value outside LOAD; only valid qualifies it.
- Reset mid-operation returns to IDLE, discards all queued entries and drops enable immediately. Coordinated reset of the timer is the integrator's responsibility.
- done_cnt wraps modulo 256 with no saturation.

Decomposition:
- Shared package timer_pkg holds:
  - W=5.
  - State encoding for IDLE=2'd0, LOAD=2'd1, ARM=2'd2, RUN=2'd3.
  - Default DEPTH=4.
- One natural sub-module: timer_loader_fifo (parameterised W/DEPTH sync FIFO with push, pop, level, full, empty, head output).
- FSM and counters stay in timer_loader.

Test Plan:
1. Reset, then push 10 → valid pulses once with value=10 two cycles later; ARM 1 cycle; enable high until the timer trigger; done pulses once; done_cnt=1; returns to IDLE with busy=0.
2. Push 3, 4, 5 back-to-back with DEPTH=4 → req_ready stays 1; level peaks at 2 (first pops immediately); three loads in order 3, 4, 5; exactly 2 dead cycles between intervals; done_cnt=3.
3. Push 5 entries while hold=1 during the first RUN → level reaches 4 with req_ready=0; the 5th is held by the producer until the pop; no entry is lost or duplicated; final done_cnt=5.
4. During RUN with value=10, assert hold for 2 cycles → enable low for exactly those 2 cycles; RUN lengthened by 2; a single done pulse.
5. Push 0 → LOAD, ARM, RUN for 1 cycle; done pulses; done_cnt increments by 1.
6. Push 8 and 6; assert reset mid-RUN of 8 → enable=0, level=0, done_cnt=0 immediately. After release, no load occurs until a new push arrives.
